la_serial_tx: RTL and testbench
===============================

Name: la_serial_tx

Overview:
Parallel-to-serial transmitter; the companion of the serial-in/128-bit-out user logic.
Captures a WIDTH-bit word from the logic-analyzer input bus on a valid/ready handshake and sends it as a framed serial stream on one bit.
Frame format: start bit, data LSB first, optional parity, stop bit.
Sits inside the user project area, clocked from the Wishbone clock.

Parameters:
WIDTH, 128, data word width in bits (>=2)
DIV, 4, wb_clk_i cycles per serial bit period (>=1)

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  asynchronous active-high reset
la_data_in  input  WIDTH  parallel word to transmit
load_valid  input  1  word on la_data_in is valid
load_ready  output  1  transmitter can accept a word (high only in IDLE)
ser_out  output  1  serial line; idles high
ser_frame  output  1  high while data bits are on ser_out
busy  output  1  frame in progress (any state except IDLE)
done  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is asynchronous and active-high; all flops clear on assertion.
- Reset values: ser_out=1, ser_frame=0, busy=0, done=0, load_ready=1, state=IDLE, counters=0, shift register=0.
- States and transitions: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- Load handshake:
  - Transfer happens when load_valid && load_ready on a rising edge.
  - The word is latched into the shift register and the FSM enters START on the next cycle.
  - la_data_in is ignored outside the transfer cycle.
  - load_valid while busy is not captured and causes no error.
- Bit timing:
  - Each state holds ser_out for exactly DIV cycles.
  - A divide counter runs 0..DIV-1; the state advances when the count reaches DIV-1.
  - DIV=1 means one bit per clock.
- START: ser_out=0.
- DATA:
  - ser_out = shift_reg[0]; ser_frame=1.
  - At each bit-period end the register shifts right by 1 and the bit index increments.
  - After index WIDTH-1 completes, go to PARITY if enabled, otherwise STOP.
- STOP:
  - ser_out=1.
  - done=1 in the final cycle of STOP; the next cycle is IDLE with load_ready=1.
- Latency:
  - First ser_out=0 appears one cycle after the load transfer.
  - Total frame length is (WIDTH+2)*DIV cycles, or (WIDTH+3)*DIV with parity.
- Back-to-back frames: earliest reload is the cycle after done. Stop bit to next start bit is one idle cycle (ser_out=1).
- Outputs are registered; ser_out is glitch-free.
- Widths: bit index is $clog2(WIDTH) bits; divide counter is max(1,$clog2(DIV)) bits. Both wrap to 0 at state change.
- Reset mid-frame: the frame is aborted immediately and ser_out returns to 1 asynchronously. No done pulse.

Optional Feature:
LA_SER_TX_PARITY_EN
- Defined:
  - PARITY state is inserted after DATA for DIV cycles.
  - ser_out = XOR of the latched word (even parity); ser_frame=0 during PARITY.
  - Frame length becomes (WIDTH+3)*DIV.
- Undefined:
  - PARITY state and parity logic are absent; DATA goes directly to STOP.

Decomposition:
- Package la_ser_pkg holds:
  - state enum tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - localparams SER_IDLE_LVL=1'b1, SER_START_LVL=1'b0
  - function ser_frame_len(WIDTH, DIV, parity_en)
- Sub-module la_bit_timer (divide counter producing a bit_tick strobe) is natural; it is reused by the matching receiver.

Test Plan:
- Reset: assert wb_rst_i mid-cycle -> ser_out=1, busy=0, load_ready=1 immediately, with no clock edge required.
- WIDTH=128, DIV=1, load 128'h1 -> ser_out sequence: 0 (start), 1, then 127 zeros, then 1 (stop). busy high 130 cycles; done pulses once in cycle 130.
- DIV=4, word 128'hA5 in the low byte -> each bit held 4 cycles; ser_frame high exactly 512 cycles; first data bits 1,0,1,0,0,1,0,1.
- Busy collision: hold load_valid=1 throughout a frame with a new word -> second word is captured only in the cycle after done; frames separated by one idle-high cycle.
- Reset mid-DATA at bit 40 -> ser_out=1 and state IDLE at once; no done pulse; the next load transmits the full new word.
- LA_SER_TX_PARITY_EN, DIV=1, word with 3 ones -> parity bit 1 before stop; frame length 131 cycles.

Source files
------------

// File: rtl/la_ser_pkg.sv
// Shared types and constants for the logic-analyzer serial transmitter.
// Optional parity is enabled by defining LA_SER_TX_PARITY_EN.
package la_ser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic SER_IDLE_LVL  = 1'b1;
    localparam logic SER_START_LVL = 1'b0;

    function automatic int unsigned ser_frame_len(input int unsigned width,
                                                  input int unsigned div,
                                                  input bit          parity_en);
        return (width + 2 + (parity_en ? 1 : 0)) * div;
    endfunction

endpackage

// File: rtl/la_bit_timer.sv
// Bit-period divider: counts 0..DIV-1 while running and strobes on the last count.
// Shared with the matching receiver.
module la_bit_timer #(
    parameter int unsigned DIV = 4,
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick,
    output logic tick_next
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    assign bit_tick  = run && (cnt_q == LAST);
    // Lets the owner register outputs that must line up with the final count.
    assign tick_next = (cnt_d == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/la_serial_tx.sv
// Framed parallel-to-serial transmitter: start, data LSB first, optional even parity, stop.
// Parity stage is built only when LA_SER_TX_PARITY_EN is defined.
module la_serial_tx
    import la_ser_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DIV   = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] la_data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             bit_tick, tick_next, run, xfer;
    logic             ser_out_d, ser_frame_d, busy_d, done_d, load_ready_d;
`ifdef LA_SER_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign run  = (state_q != IDLE);
    assign xfer = load_valid && load_ready;

    la_bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .run      (run),
        .bit_tick (bit_tick),
        .tick_next(tick_next)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef LA_SER_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = START;
                    shift_d = la_data_in;
`ifdef LA_SER_TX_PARITY_EN
                    parity_d = ^la_data_in;
`endif
                end
            end
            START: begin
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_BIT) begin
                        idx_d = '0;
`ifdef LA_SER_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
`ifdef LA_SER_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins change with the state.
    always_comb begin
        ser_out_d   = SER_IDLE_LVL;
        ser_frame_d = 1'b0;
        case (state_d)
            START: ser_out_d = SER_START_LVL;
            DATA: begin
                ser_out_d   = shift_d[0];
                ser_frame_d = 1'b1;
            end
`ifdef LA_SER_TX_PARITY_EN
            PARITY: ser_out_d = parity_d;
`endif
            default: ser_out_d = SER_IDLE_LVL;
        endcase
        busy_d       = (state_d != IDLE);
        load_ready_d = (state_d == IDLE);
        done_d       = (state_d == STOP) && tick_next;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            ser_out    <= SER_IDLE_LVL;
            ser_frame  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef LA_SER_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            ser_out    <= ser_out_d;
            ser_frame  <= ser_frame_d;
            busy       <= busy_d;
            done       <= done_d;
            load_ready <= load_ready_d;
`ifdef LA_SER_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_la_serial_tx.sv
// Self-checking bench for la_serial_tx: one DIV=1 and one DIV=4 instance against a frame model.
// Honours LA_SER_TX_PARITY_EN when defined for the build.
module tb_la_serial_tx;

    localparam int WIDTH = 128;
`ifdef LA_SER_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] data       [2];
    logic             load_valid [2];
    logic             load_ready [2];
    logic             ser_out    [2];
    logic             ser_frame  [2];
    logic             busy       [2];
    logic             done       [2];

    int passed;
    int total;

    always #5 clk = ~clk;

    la_serial_tx #(.WIDTH(WIDTH), .DIV(1)) u_dut_div1 (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .la_data_in(data[0]),
        .load_valid(load_valid[0]),
        .load_ready(load_ready[0]),
        .ser_out   (ser_out[0]),
        .ser_frame (ser_frame[0]),
        .busy      (busy[0]),
        .done      (done[0])
    );

    la_serial_tx #(.WIDTH(WIDTH), .DIV(4)) u_dut_div4 (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .la_data_in(data[1]),
        .load_valid(load_valid[1]),
        .load_ready(load_ready[1]),
        .ser_out   (ser_out[1]),
        .ser_frame (ser_frame[1]),
        .busy      (busy[1]),
        .done      (done[1])
    );

    function automatic int div_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Returns at a negedge with the DUT idle, or records a timeout failure.
    task automatic wait_ready(input int d, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (load_ready[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (load_ready[d] !== 1'b1) begin
            total++;
            $display("FAIL %s ready_timeout: load_ready=%b after %0d cycles, required 1", name,
                     load_ready[d], n);
        end
    endtask

    task automatic send(input int d, input logic [WIDTH-1:0] w, input bit hold,
                        input string name);
        wait_ready(d, name);
        data[d]       = w;
        load_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) load_valid[d] = 1'b0;
    endtask

    // Samples one whole frame starting the cycle after the transfer edge.
    task automatic check_frame(input int d, input logic [WIDTH-1:0] word, input string name,
                               output logic [WIDTH-1:0] rx);
        int   div, len, b, first;
        int   bad_out, bad_frm, bad_busy, bad_rdy, frm_cnt, done_cnt, done_at;
        logic exp_out, exp_frm;
        div = div_of(d);
        len = (WIDTH + 2 + PAR) * div;
        bad_out = 0; bad_frm = 0; bad_busy = 0; bad_rdy = 0;
        frm_cnt = 0; done_cnt = 0; done_at = -1; first = -1;
        rx = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            b = i / div;
            if (b == 0) exp_out = 1'b0;
            else if (b <= WIDTH) exp_out = word[b-1];
            else if (PAR == 1 && b == WIDTH + 1) exp_out = ^word;
            else exp_out = 1'b1;
            exp_frm = (b >= 1 && b <= WIDTH);
            if (ser_out[d] !== exp_out) begin
                bad_out++;
                if (first < 0) first = i;
            end
            if (ser_frame[d] !== exp_frm) bad_frm++;
            if (busy[d] !== 1'b1) bad_busy++;
            if (load_ready[d] !== 1'b0) bad_rdy++;
            if (ser_frame[d] === 1'b1) frm_cnt++;
            if (done[d] === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            if (exp_frm && (i % div) == 0) rx[b-1] = ser_out[d];
        end
        total++;
        if (bad_out !== 0) $display("FAIL %s ser_out: %0d wrong cycles (first %0d), required 0",
                                    name, bad_out, first);
        else passed++;
        total++;
        if (bad_frm !== 0) $display("FAIL %s ser_frame: %0d wrong cycles, required 0", name,
                                    bad_frm);
        else passed++;
        total++;
        if (bad_busy !== 0) $display("FAIL %s busy: %0d low cycles, required 0", name, bad_busy);
        else passed++;
        total++;
        if (bad_rdy !== 0) $display("FAIL %s load_ready: %0d high cycles in frame, required 0",
                                    name, bad_rdy);
        else passed++;
        total++;
        if (frm_cnt !== WIDTH * div) $display("FAIL %s frame_len: %0d, required %0d", name,
                                              frm_cnt, WIDTH * div);
        else passed++;
        total++;
        if (done_cnt !== 1 || done_at !== len - 1)
            $display("FAIL %s done: %0d pulses last at %0d, required 1 at %0d", name, done_cnt,
                     done_at, len - 1);
        else passed++;
    endtask

    task automatic check_idle(input int d, input string name);
        @(negedge clk);
        total++;
        if ({ser_out[d], busy[d], load_ready[d], done[d]} !== 4'b1010)
            $display("FAIL %s idle: ser_out/busy/ready/done=%b%b%b%b, required 1010", name,
                     ser_out[d], busy[d], load_ready[d], done[d]);
        else passed++;
    endtask

    task automatic check_reset_outs(input int d, input string name);
        total++;
        if ({ser_out[d], ser_frame[d], busy[d], done[d], load_ready[d]} !== 5'b10001)
            $display("FAIL %s rst_outs: out/frame/busy/done/ready=%b%b%b%b%b, required 10001",
                     name, ser_out[d], ser_frame[d], busy[d], done[d], load_ready[d]);
        else passed++;
    endtask

    task automatic check_rx(input logic [WIDTH-1:0] rx, input logic [WIDTH-1:0] word,
                            input string name);
        total++;
        if (rx !== word) $display("FAIL %s rx_word: %h, required %h", name, rx, word);
        else passed++;
    endtask

    task automatic test_reset();
        #1;
        check_reset_outs(0, "reset_d1");
        check_reset_outs(1, "reset_d4");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outs(0, "release_d1");
        check_reset_outs(1, "release_d4");
        send(1, rand_word(), 1'b0, "async_rst");
        repeat (6) @(negedge clk);
        total++;
        if (busy[1] !== 1'b1) $display("FAIL async_rst busy_pre: %b, required 1", busy[1]);
        else passed++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outs(1, "async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_div1_one();
        logic [WIDTH-1:0] w, rx;
        w = 1;
        send(0, w, 1'b0, "div1_one");
        check_frame(0, w, "div1_one", rx);
        check_rx(rx, w, "div1_one");
        check_idle(0, "div1_one");
    endtask

    task automatic test_div4_a5();
        logic [WIDTH-1:0] w, rx;
        logic [7:0]       low;
        w = 'hA5;
        send(1, w, 1'b0, "div4_a5");
        check_frame(1, w, "div4_a5", rx);
        low = rx[7:0];
        total++;
        if (low !== 8'b1010_0101) $display("FAIL div4_a5 first_bits: %b, required 10100101", low);
        else passed++;
        check_idle(1, "div4_a5");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] w, rx;
        for (int n = 0; n < 3; n++) begin
            for (int d = 0; d < 2; d++) begin
                w = rand_word();
                send(d, w, 1'b0, "random");
                check_frame(d, w, "random", rx);
                check_rx(rx, w, "random");
                check_idle(d, "random");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a, b, rx;
        for (int d = 0; d < 2; d++) begin
            a = rand_word();
            b = rand_word();
            send(d, a, 1'b1, "b2b_first");
            data[d] = b;
            check_frame(d, a, "b2b_first", rx);
            check_rx(rx, a, "b2b_first");
            check_idle(d, "b2b_gap");
            @(posedge clk);
            #1 load_valid[d] = 1'b0;
            check_frame(d, b, "b2b_second", rx);
            check_rx(rx, b, "b2b_second");
            check_idle(d, "b2b_second");
        end
    endtask

    task automatic test_reset_mid_data();
        logic [WIDTH-1:0] w, rx;
        int               dones;
        for (int d = 0; d < 2; d++) begin
            w = rand_word();
            send(d, w, 1'b0, "mid_rst");
            for (int i = 0; i <= 41 * div_of(d); i++) @(negedge clk);
            total++;
            if ({ser_frame[d], ser_out[d]} !== {1'b1, w[40]})
                $display("FAIL mid_rst bit40: frame/out=%b%b, required 1%b", ser_frame[d],
                         ser_out[d], w[40]);
            else passed++;
            @(posedge clk);
            #2 rst = 1'b1;
            #1 check_reset_outs(d, "mid_rst");
            dones = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done[d] === 1'b1) dones++;
            end
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done[d] === 1'b1) dones++;
            end
            total++;
            if (dones !== 0) $display("FAIL mid_rst no_done: %0d pulses, required 0", dones);
            else passed++;
            check_idle(d, "mid_rst_idle");
            w = rand_word();
            send(d, w, 1'b0, "mid_rst_next");
            check_frame(d, w, "mid_rst_next", rx);
            check_rx(rx, w, "mid_rst_next");
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        for (int d = 0; d < 2; d++) begin
            data[d]       = '0;
            load_valid[d] = 1'b0;
        end
        rst = 1'b1;
        test_reset();
        test_div1_one();
        test_div4_a5();
        test_random();
        test_back_to_back();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", passed,
                 total);
        $fatal(1, "watchdog");
    end

endmodule
